// File: rtl/animator_interp.sv
// Keyframe animator: per frame request, bumps the wrapping frame clock, derives one
// interpolation fraction with a restoring divider, then rewrites every channel.
module animator_interp #(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = 12,
    parameter int c_max_time  = 1024,
    parameter int c_frac_w    = 10,
    parameter int c_rd_lat    = 1,
    parameter int c_channels  = c_ledboards * 32,
    parameter int c_addr_w    = $clog2(c_channels),
    parameter int c_time_w    = $clog2(c_max_time)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_drq,
    input  logic [1:0]          i_mode,
    input  logic [c_time_w-1:0] i_start_time,
    input  logic [c_time_w-1:0] i_target_time,
    input  logic [c_bpc-1:0]    i_current_data,
    input  logic [c_bpc-1:0]    i_target_data,
    output logic [c_addr_w-1:0] o_addr,
    output logic                o_wen,
    output logic [c_bpc-1:0]    o_data,
    output logic [c_time_w-1:0] o_time,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overrun
);

    localparam int c_div_cw = $clog2(c_frac_w + 1);
    localparam int c_prod_w = c_bpc + c_frac_w + 3;
    localparam int c_sq_w   = 2 * c_frac_w + 2;

    localparam logic [1:0] m_step = 2'd0;
    localparam logic [1:0] m_ease = 2'd2;
    localparam logic [1:0] m_hold = 2'd3;

    typedef enum logic [2:0] {s_idle, s_div, s_read, s_calc, s_write, s_end} state_t;

    state_t state, state_nxt;

    logic [1:0]          mode_r;
    logic [c_time_w-1:0] start_r, target_r;
    logic [c_time_w-1:0] rem;
    logic [c_frac_w-1:0] quot;
    logic [c_div_cw-1:0] div_cnt;
    logic [c_rd_lat:0]   vld_pipe;
    logic                launch;
    logic                accept;
    logic                last_ch;

    assign accept  = (state == s_idle) && i_drq;
    assign last_ch = (o_addr == c_addr_w'(c_channels - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= s_idle;
        else          state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            s_idle:  if (i_drq) state_nxt = s_div;
            s_div:   if (div_cnt == c_div_cw'(c_frac_w - 1)) state_nxt = s_read;
            s_read:  if (vld_pipe[c_rd_lat-1]) state_nxt = s_calc;
            s_calc:  state_nxt = s_write;
            s_write: state_nxt = last_ch ? s_end : s_read;
            s_end:   state_nxt = s_idle;
            default: state_nxt = s_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy = (state != s_idle);
        o_done = (state == s_end);
        o_wen  = (state == s_write) && (mode_r != m_hold);
        launch = (state_nxt == s_read) && (state != s_read);
    end

    // ---------------- divider ----------------
    // Quotient is only needed when e < d, so the remainder starts at e and the
    // F quotient bits fall out in exactly F steps; saturation is decided separately.
    logic [c_time_w-1:0] e_w, d_w, rem_cur;
    logic [c_time_w:0]   r2, r_sub;
    logic                r_ge, sat;

    assign e_w     = o_time - start_r;
    assign d_w     = target_r - start_r;
    assign sat     = (d_w == '0) || (e_w >= d_w);
    assign rem_cur = (div_cnt == '0) ? e_w : rem;
    assign r2      = {rem_cur, 1'b0};
    assign r_ge    = (r2 >= {1'b0, d_w});
    assign r_sub   = r2 - {1'b0, d_w};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_time    <= '0;
            o_addr    <= '0;
            mode_r    <= '0;
            start_r   <= '0;
            target_r  <= '0;
            rem       <= '0;
            quot      <= '0;
            div_cnt   <= '0;
            vld_pipe  <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= i_drq && (state != s_idle);
            vld_pipe  <= {vld_pipe[c_rd_lat-1:0], launch};
            if (accept) begin
                o_time   <= o_time + c_time_w'(1);
                mode_r   <= i_mode;
                start_r  <= i_start_time;
                target_r <= i_target_time;
                o_addr   <= '0;
                div_cnt  <= '0;
                quot     <= '0;
            end
            if (state == s_div) begin
                div_cnt <= div_cnt + c_div_cw'(1);
                rem     <= r_ge ? r_sub[c_time_w-1:0] : r2[c_time_w-1:0];
                quot    <= {quot[c_frac_w-2:0], r_ge};
            end
            if (state == s_write && !last_ch)
                o_addr <= o_addr + c_addr_w'(1);
        end
    end

    // ---------------- channel interpolation ----------------
    logic [c_frac_w:0]            frac, f_ease, f_sel;
    logic [c_sq_w-1:0]            sq;
    logic signed [c_prod_w-1:0]   diff_x, f_x, prod;
    logic [c_bpc-1:0]             lerp, result;

    assign frac   = sat ? {1'b1, {c_frac_w{1'b0}}} : {1'b0, quot};
    assign sq     = c_sq_w'(frac) * c_sq_w'(frac);
    assign f_ease = sq[2*c_frac_w:c_frac_w];
    assign f_sel  = (mode_r == m_ease) ? f_ease : frac;

    assign diff_x = c_prod_w'($signed({1'b0, i_target_data}))
                  - c_prod_w'($signed({1'b0, i_current_data}));
    assign f_x    = c_prod_w'($signed({1'b0, f_sel}));
    assign prod   = diff_x * f_x;
    // Arithmetic shift by F then truncation: the true result is bounded by cur/tgt,
    // so modular c_bpc-bit addition is exact.
    assign lerp   = i_current_data + prod[c_frac_w +: c_bpc];

    always_comb begin
        case (mode_r)
            m_step:  result = frac[c_frac_w] ? i_target_data : i_current_data;
            m_hold:  result = i_current_data;
            default: result = lerp;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                               o_data <= '0;
        else if (state == s_calc && vld_pipe[c_rd_lat]) o_data <= result;
    end

    logic unused_bits;
    assign unused_bits = ^{prod[c_frac_w-1:0], prod[c_prod_w-1:c_frac_w+c_bpc],
                           sq[c_sq_w-1], sq[c_frac_w-1:0], r_sub[c_time_w]};

endmodule

// File: tb/tb_animator_interp.sv
// Directed bench for animator_interp: small config (1 board, 16-step clock, F=8),
// keyframe memories modelled as 1-cycle synchronous reads.
module tb_animator_interp;

    localparam int BPC = 12, MT = 16, FW = 8, RL = 1, CH = 32, AW = 5, TW = 4;
    localparam int LAT = 1 + FW + CH * (RL + 2);

    logic          i_clk = 1'b0, i_rst_n = 1'b0, i_drq = 1'b0;
    logic [1:0]    i_mode = '0;
    logic [TW-1:0] i_start_time = '0, i_target_time = '0;
    logic [BPC-1:0] i_current_data, i_target_data;
    logic [AW-1:0] o_addr;
    logic          o_wen, o_busy, o_done, o_overrun;
    logic [BPC-1:0] o_data;
    logic [TW-1:0] o_time;

    logic [BPC-1:0] cur_mem [CH];
    logic [BPC-1:0] tgt_mem [CH];
    int             exp_mem [CH];

    int checks = 0, errors = 0;

    animator_interp #(
        .c_ledboards(1), .c_bpc(BPC), .c_max_time(MT), .c_frac_w(FW), .c_rd_lat(RL)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_drq(i_drq), .i_mode(i_mode),
        .i_start_time(i_start_time), .i_target_time(i_target_time),
        .i_current_data(i_current_data), .i_target_data(i_target_data),
        .o_addr(o_addr), .o_wen(o_wen), .o_data(o_data), .o_time(o_time),
        .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        i_current_data <= cur_mem[o_addr];
        i_target_data  <= tgt_mem[o_addr];
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic fill(input int c0, input int cs, input int t0, input int ts,
                        input int e0, input int es);
        for (int i = 0; i < CH; i++) begin
            cur_mem[i] = BPC'(c0 + cs * i);
            tgt_mem[i] = BPC'(t0 + ts * i);
            exp_mem[i] = e0 + es * i;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_time"}, int'(o_time), 0);
        chk({tag, "_addr"}, int'(o_addr), 0);
        chk({tag, "_data"}, int'(o_data), 0);
        chk({tag, "_wen"},  int'(o_wen), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
        chk({tag, "_ovr"},  int'(o_overrun), 0);
    endtask

    // One frame: pulse drq for one cycle, check every write, then latency and count.
    task automatic run_frame(input int mode, input int st, input int tg, input int exp_t,
                             input int exp_wr, input int ovr_at);
        int cyc, nwr;
        logic prev;
        @(posedge i_clk); #1;
        i_mode = 2'(mode); i_start_time = TW'(st); i_target_time = TW'(tg); i_drq = 1'b1;
        @(posedge i_clk); #1;
        i_drq = 1'b0; cyc = 1; nwr = 0; prev = 1'b0;
        chk("busy", int'(o_busy), 1);
        chk("time", int'(o_time), exp_t);
        while (cyc < LAT + 50) begin
            @(negedge i_clk);
            if (o_wen) begin
                chk("wen_b2b", int'(prev), 0);
                chk("addr", int'(o_addr), nwr);
                chk("data", int'(o_data), exp_mem[nwr % CH]);
                nwr++;
            end
            prev = o_wen;
            if (ovr_at > 0 && cyc == ovr_at + 1) begin
                chk("ovr", int'(o_overrun), 1);
                chk("ovr_time", int'(o_time), exp_t);
            end
            if (ovr_at > 0 && cyc == ovr_at + 2) chk("ovr_pulse", int'(o_overrun), 0);
            if (o_done) break;
            @(posedge i_clk); cyc++; #1;
            i_drq = (ovr_at > 0 && cyc == ovr_at);
        end
        i_drq = 1'b0;
        chk("done_lat", cyc, LAT);
        chk("nwr", nwr, exp_wr);
        @(negedge i_clk);
        chk("idle", int'(o_busy), 0);
        chk("done_pulse", int'(o_done), 0);
    endtask

    initial begin
        int nwr, nbad;
        fill(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge i_clk);
        #1 chk_zero("rst");
        i_rst_n = 1'b1;

        fill(0, 0, 4095, 0, 511, 0);     run_frame(1, 0, 8, 1, CH, 0);   // frac 32
        fill(4095, 0, 0, 0, 3583, 0);    run_frame(1, 1, 9, 2, CH, 0);   // negative floor
        fill(4000, 0, 100, 1, 100, 1);   run_frame(1, 5, 5, 3, CH, 0);   // d==0
        fill(0, 3, 1000, 1, 0, 3);       run_frame(0, 0, 8, 4, CH, 0);   // step, e<d
        fill(0, 3, 1000, 1, 1000, 1);    run_frame(0, 0, 5, 5, CH, 0);   // step, e==d
        fill(0, 0, 1024, 0, 256, 0);     run_frame(2, 2, 10, 6, CH, 0);  // ease-in
        run_frame(3, 0, 8, 7, 0, 40);                                    // hold + overrun
        for (int t = 8; t < 14; t++) run_frame(3, 0, 0, t, 0, 0);
        fill(100, 0, 500, 0, 100, 0);    run_frame(1, 14, 2, 14, CH, 0); // e=0
        fill(100, 0, 500, 0, 200, 0);    run_frame(1, 14, 2, 15, CH, 0); // frac 64
        fill(100, 0, 500, 0, 300, 0);    run_frame(1, 14, 2, 0, CH, 0);  // wrapped
        fill(100, 0, 500, 0, 400, 0);    run_frame(1, 14, 2, 1, CH, 0);
        fill(100, 0, 500, 0, 500, 0);    run_frame(1, 14, 2, 2, CH, 0);  // e==d

        // Reset mid-frame (T=3, frac 96 -> 1535), writes in flight before it.
        fill(0, 0, 4095, 0, 1535, 0);
        @(posedge i_clk); #1;
        i_mode = 2'd1; i_start_time = TW'(0); i_target_time = TW'(8); i_drq = 1'b1;
        @(posedge i_clk); #1 i_drq = 1'b0;
        nwr = 0; nbad = 0;
        for (int c = 1; c < 50; c++) begin
            @(negedge i_clk);
            if (o_wen) begin
                nwr++;
                if (int'(o_data) != 1535) nbad++;
            end
            @(posedge i_clk);
        end
        chk("pre_rst_wr", nwr, 13);
        chk("pre_rst_data_bad", nbad, 0);
        #1 i_rst_n = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        nwr = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge i_clk);
            if (o_wen || o_busy) nwr++;
        end
        chk("post_rst_activity", nwr, 0);

        fill(0, 0, 4095, 0, 511, 0);     run_frame(1, 0, 8, 1, CH, 0);   // recovers from T=0

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/animator_interp.md
Name: animator_interp

Overview:
- Second-generation keyframe animator for the LED frame buffer.
- On each frame request, advances the wrapping frame-time counter and computes one interpolation fraction per frame with a sequential divider.
- Then walks every channel: reads current/target values, applies the selected animation mode, writes the result.
- Sits between the keyframe memories and the frame buffer feeding the LED-board serialiser.

Parameters:
- c_ledboards, 30, number of LED boards.
- c_bpc, 12, bits per colour channel.
- c_max_time, 1024, time-counter modulus (power of two).
- c_frac_w, 10, interpolation fraction bits (F).
- c_rd_lat, 1, keyframe-memory read latency in cycles (>=1).
- c_channels, c_ledboards*32, channel count.
- c_addr_w, $clog2(c_channels), address width.
- c_time_w, $clog2(c_max_time), time width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_drq  in  1  frame request, level sampled in s_idle.
- i_mode  in  2  0=step, 1=linear, 2=ease-in, 3=hold; latched on accepted drq.
- i_start_time  in  c_time_w  keyframe start time; latched on accepted drq.
- i_target_time  in  c_time_w  keyframe target time; latched on accepted drq.
- i_current_data  in  c_bpc  current-keyframe read data, valid c_rd_lat cycles after o_addr.
- i_target_data  in  c_bpc  target-keyframe read data, same timing.
- o_addr  out  c_addr_w  shared read/write channel address.
- o_wen  out  1  frame-buffer write strobe.
- o_data  out  c_bpc  write data.
- o_time  out  c_time_w  frame-time counter.
- o_busy  out  1  high outside s_idle.
- o_done  out  1  one-cycle pulse, frame complete.
- o_overrun  out  1  one-cycle pulse, drq arrived while busy.

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs and the counter go to 0; state goes to s_idle.
  - Reset mid-frame aborts immediately; no further o_wen.
- States: s_idle, s_div, s_read, s_calc, s_write, s_end.
- s_idle, on i_drq=1:
  - o_time <= (o_time+1) mod c_max_time.
  - Latch mode and both times; o_addr <= 0; go to s_div.
- s_div, lasts exactly c_frac_w cycles, restoring divider:
  - T is the post-increment o_time.
  - e = (T - start) mod c_max_time; d = (target - start) mod c_max_time.
  - If d==0 or e>=d: frac = 2^F.
  - Else frac = floor(e*2^F/d), which is < 2^F.
  - Cycle count is the same in every case.
- s_read:
  - Holds o_addr for c_rd_lat cycles, then goes to s_calc.
- s_calc, samples data (cur, tgt) and registers the result, by mode:
  - step: result = tgt if frac==2^F, else cur.
  - linear: f = frac.
  - ease-in: f = (frac*frac)>>F.
  - linear and ease-in: result = cur + floor((tgt-cur)*f / 2^F).
  - Difference is signed c_bpc+1 bits; shift is arithmetic (floor toward -inf).
  - The result always lies within [min(cur,tgt), max(cur,tgt)]; no clamp is needed.
  - hold: result = cur.
- s_write, one cycle:
  - o_wen=1 with o_addr and o_data valid.
  - hold mode keeps o_wen=0.
  - If o_addr==c_channels-1, go to s_end; else o_addr+1 and go to s_read.
- s_end: o_done=1 for one cycle; go to s_idle.
- Frame latency from accepted drq to o_done: 1 + c_frac_w + c_channels*(c_rd_lat+2) cycles.
- Per-channel cadence: one write every c_rd_lat+2 cycles.
- i_drq=1 in any state other than s_idle:
  - o_overrun pulses (one cycle per cycle seen).
  - Request is dropped; counter unchanged.
- Counter wraps c_max_time-1 -> 0; the modular e/d arithmetic handles keyframes spanning the wrap.
- o_wen is never high in two consecutive cycles.

Test Plan:
Bench parameters: c_ledboards=1, c_max_time=16, c_frac_w=8, c_rd_lat=1.
1. Reset, then drq with linear, start=0, target=8 (T=1, frac=32), all cur=0, tgt=4095:
   - 32 writes of 511, addresses 0..31 in order.
   - o_done 1+8+96=105 cycles after accept.
2. Same timing, cur=4095, tgt=0:
   - Every write is 3583 (floor of -511.875 is -512).
3. Wrap: counter preset to 14 via drq, start=14, target=2, linear; next drq gives T=15, e=1, d=4, frac=64:
   - cur=100, tgt=500 -> 200.
4. start=target=0 (d=0), linear:
   - Writes tgt exactly.
   - Step mode with e<d writes cur; once e>=d, step writes tgt.
5. Ease-in, e=4, d=8 (frac=128, f=64), cur=0, tgt=1024:
   - Writes 256.
6. Hold mode:
   - No o_wen for the whole frame; o_done still at 105.
   - drq pulsed mid-frame -> o_overrun pulse, o_time unchanged.
   - Reset asserted at cycle 50 -> all outputs 0 at once, no writes after release.
